// File: rtl/enigma_pkg.sv
// enigma_pkg
// Shared types and constants for the letter transmit path.
//   txState_e         : states of the transmit-queue controller
//   TERM_CODE_DEFAULT : letter code sent as an end-of-burst terminator
//   wrapIncr          : pointer increment that wraps at an arbitrary depth
//   satInc16          : 16-bit increment that sticks at all-ones
package enigma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_TERM
  } txState_e;

  localparam logic [4:0]  TERM_CODE_DEFAULT = 5'd31;
  localparam logic [15:0] SAT_MAX16         = 16'hFFFF;

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic int wrapIncr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == SAT_MAX16) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/circ_buffer.sv
// circ_buffer
// Circular letter store with independent read and write pointers.
//   clk_in       : clock, rising edge
//   rst_in       : synchronous active-low reset (pointers and count only)
//   flush_in     : empties the buffer on the next edge
//   push_in      : write push_data_in at the tail (caller guarantees room)
//   push_data_in : letter to store
//   pop_in       : advance the head (caller guarantees not empty)
//   head_out     : letter at the head, valid whenever count_out != 0
//   count_out    : current occupancy, 0..DEPTH
module circ_buffer
  import enigma_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic                       push_in,
  input  logic [DATA_WIDTH-1:0]      push_data_in,
  input  logic                       pop_in,
  output logic [DATA_WIDTH-1:0]      head_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W-1:0]      r_wrPtr;
  logic [CNT_W-1:0]      r_count;

  // The storage array carries no reset; stale entries are never visible
  // because the count gates every read.
  always_ff @(posedge clk_in) begin
    if (push_in) begin
      r_mem[r_wrPtr] <= push_data_in;
    end
  end

  // Pointers and occupancy. A simultaneous push and pop leaves the count
  // untouched, which is what lets a full buffer accept a write while the
  // head is being popped.
  always_ff @(posedge clk_in) begin
    if (!rst_in || flush_in) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (push_in) begin
        r_wrPtr <= PTR_W'(wrapIncr(int'(r_wrPtr), DEPTH));
      end
      if (pop_in) begin
        r_rdPtr <= PTR_W'(wrapIncr(int'(r_rdPtr), DEPTH));
      end
      case ({push_in, pop_in})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_out  = r_mem[r_rdPtr];
  assign count_out = r_count;

endmodule

// File: rtl/tx_letter_queue.sv
// tx_letter_queue
// Buffers encoded letters and hands them one at a time to the IR transmitter,
// re-issuing a letter whenever the transmitter fails to acknowledge it.
//   clk_in          : clock, rising edge
//   rst_in          : synchronous active-low reset
//   data_valid_in   : one-cycle write strobe, data_in is the letter
//   flush_in        : discard every queued letter
//   tx_busy_in      : transmitter busy flag (acknowledge + completion)
//   tx_valid_out    : one-cycle start pulse, tx_data_out holds the letter
//   full_out        : occupancy equals DEPTH
//   empty_out       : occupancy is zero
//   count_out       : occupancy
//   drop_count_out  : saturating count of writes refused for lack of room
//   retry_count_out : saturating count of acknowledge timeouts
module tx_letter_queue
  import enigma_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 5,
  parameter int                    DEPTH       = 16,
  parameter int                    ACK_TIMEOUT = 8,
  parameter bit                    TERM_EN     = 1'b0,
  parameter logic [DATA_WIDTH-1:0] TERM_CODE   = DATA_WIDTH'(TERM_CODE_DEFAULT)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       data_valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       flush_in,
  input  logic                       tx_busy_in,
  output logic                       tx_valid_out,
  output logic [DATA_WIDTH-1:0]      tx_data_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic [15:0]                drop_count_out,
  output logic [15:0]                retry_count_out
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  txState_e              r_state;
  txState_e              w_nextState;
  logic [DATA_WIDTH-1:0] r_txData;
  logic [DATA_WIDTH-1:0] w_head;
  logic [CNT_W-1:0]      w_count;
  logic [TMR_W-1:0]      r_ackTimer;
  logic                  r_termPending;
  logic                  r_termActive;
  logic [15:0]           r_dropCount;
  logic [15:0]           r_retryCount;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_termLoad;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_done;
  logic                  w_valid;
  logic                  w_retry;

  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == CNT_W'(DEPTH));

  // Flush wins over everything in the same cycle: no pop, no terminator
  // load, and the concurrent write is silently discarded rather than dropped.
  // A terminator is never loaded in a cycle that also brings a new letter.
  assign w_pop      = (r_state == ST_IDLE) && !w_empty && !flush_in;
  assign w_termLoad = (r_state == ST_IDLE) && w_empty && r_termPending &&
                      !flush_in && !data_valid_in;
  assign w_push     = data_valid_in && !flush_in && (!w_full || w_pop);
  assign w_drop     = data_valid_in && !flush_in && !w_push;
  assign w_done     = (r_state == ST_WAIT_DONE) && !tx_busy_in;

  circ_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buffer (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .flush_in     (flush_in),
    .push_in      (w_push),
    .push_data_in (data_in),
    .pop_in       (w_pop),
    .head_out     (w_head),
    .count_out    (w_count)
  );

  // Next-state and pulse decode. WAIT_ACK spends ACK_TIMEOUT+1 cycles
  // counting before giving up, so an unacknowledged letter repeats every
  // ACK_TIMEOUT+2 cycles including the ISSUE cycle. Finishing the
  // terminator passes through TERM so its in-flight marker is retired.
  always_comb begin
    w_nextState = r_state;
    w_valid     = 1'b0;
    w_retry     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pop || w_termLoad) begin
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_valid     = 1'b1;
        w_nextState = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_busy_in) begin
          w_nextState = ST_WAIT_DONE;
        end else if (r_ackTimer == TMR_W'(ACK_TIMEOUT)) begin
          w_retry     = 1'b1;
          w_nextState = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_in) begin
          w_nextState = r_termActive ? ST_TERM : ST_IDLE;
        end
      end
      ST_TERM: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any letter in flight.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Outgoing letter register, held from the pop until the next pop or
  // terminator load so that retries resend the same code.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_txData     <= '0;
      r_termActive <= 1'b0;
    end else if (w_pop) begin
      r_txData     <= w_head;
      r_termActive <= 1'b0;
    end else if (w_termLoad) begin
      r_txData     <= TERM_CODE;
      r_termActive <= 1'b1;
    end else if (r_state == ST_TERM) begin
      r_termActive <= 1'b0;
    end
  end

  // Acknowledge timer, restarted on every issue.
  always_ff @(posedge clk_in) begin
    if (!rst_in || r_state == ST_ISSUE) begin
      r_ackTimer <= '0;
    end else if (r_state == ST_WAIT_ACK && !tx_busy_in && !w_retry) begin
      r_ackTimer <= r_ackTimer + TMR_W'(1);
    end
  end

  // Terminator request: raised when an ordinary letter finishes and nothing
  // is left behind it; any new write or a flush cancels it.
  always_ff @(posedge clk_in) begin
    if (!rst_in || flush_in) begin
      r_termPending <= 1'b0;
    end else if (data_valid_in || w_termLoad) begin
      r_termPending <= 1'b0;
    end else if (TERM_EN && w_done && !r_termActive && w_empty) begin
      r_termPending <= 1'b1;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_dropCount  <= '0;
      r_retryCount <= '0;
    end else begin
      if (w_drop) begin
        r_dropCount <= satInc16(r_dropCount);
      end
      if (w_retry) begin
        r_retryCount <= satInc16(r_retryCount);
      end
    end
  end

  assign tx_valid_out    = w_valid;
  assign tx_data_out     = r_txData;
  assign full_out        = w_full;
  assign empty_out       = w_empty;
  assign count_out       = w_count;
  assign drop_count_out  = r_dropCount;
  assign retry_count_out = r_retryCount;

endmodule
